// File: rtl/forex_update_ctrl_if.sv
// forex_update_ctrl_if
//   Bundles the signals of the forex_update_ctrl block:
//   - Avalon-MM register port (chipselect/write/read/address/writedata/readdata)
//   - graph-store update stream (upd_valid/upd_ready/upd_src/upd_dst/upd_weight)
//   - Bellman-Ford core control (core_src/core_start/core_done)
//   - level interrupt (irq)
//   The slave modport is the controller's view; master is the environment's view.
interface forex_update_ctrl_if #(
    parameter int NODES    = 8,
    parameter int WEIGHT_W = 32
);
    localparam int PW = (NODES > 1) ? $clog2(NODES) : 1;

    logic                chipselect;
    logic                write;
    logic                read;
    logic [2:0]          address;
    logic [31:0]         writedata;
    logic [31:0]         readdata;
    logic                upd_valid;
    logic                upd_ready;
    logic [PW-1:0]       upd_src;
    logic [PW-1:0]       upd_dst;
    logic [WEIGHT_W-1:0] upd_weight;
    logic [PW-1:0]       core_src;
    logic                core_start;
    logic                core_done;
    logic                irq;

    modport slave (
        input  chipselect, write, read, address, writedata, upd_ready, core_done,
        output readdata, upd_valid, upd_src, upd_dst, upd_weight, core_src, core_start, irq
    );

    modport master (
        output chipselect, write, read, address, writedata, upd_ready, core_done,
        input  readdata, upd_valid, upd_src, upd_dst, upd_weight, core_src, core_start, irq
    );
endinterface

// File: rtl/forex_update_ctrl.sv
// forex_update_ctrl
//   Avalon-MM front-end for the arbitrage engine. Edge-weight updates written
//   by the HPS are queued in a FIFO, drained into the graph store, and then a
//   Bellman-Ford run is launched on the core (manual start or automatic after
//   a drain). Status and run count are readable; irq flags run completion.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high
//   bus    - forex_update_ctrl_if.slave (register port, update stream,
//            core control, irq)
module forex_update_ctrl #(
    parameter int NODES      = 8,
    parameter int WEIGHT_W   = 32,
    parameter int FIFO_DEPTH = 8
) (
    input logic               clk,
    input logic               reset,
    forex_update_ctrl_if.slave bus
);
    localparam int PW = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * PW + WEIGHT_W;

    typedef enum logic [1:0] {IDLE, DRAIN, START, RUN} state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   src_stg_q, src_stg_d, dst_stg_q, dst_stg_d;
    logic [PW-1:0]   core_src_q, core_src_d;
    logic            start_pend_q, start_pend_d;
    logic            auto_q, auto_d;
    logic            irq_en_q, irq_en_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic            bad_edge_q, bad_edge_d;
    logic            core_start_q, core_start_d;
    logic [31:0]     run_count_q, run_count_d;
    logic [31:0]     readdata_q, readdata_d;

    logic            wr_en, rd_en, empty, full, upd_valid, pop, push;
    logic [EW-1:0]   head, push_entry;
    logic [31:0]     status;

    always_comb begin
        wr_en      = bus.chipselect && bus.write;
        rd_en      = bus.chipselect && bus.read;
        empty      = (count_q == '0);
        full       = (count_q == CW'(FIFO_DEPTH));
        head       = mem_q[rd_ptr_q];
        upd_valid  = (state_q == DRAIN) && !empty;
        pop        = upd_valid && bus.upd_ready;
        push_entry = {src_stg_q, dst_stg_q, bus.writedata[WEIGHT_W-1:0]};
        status     = {16'h0000, 8'(count_q), auto_q, start_pend_q, bad_edge_q,
                      done_q, ovf_q, empty, full, (state_q != IDLE)};
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        src_stg_d    = src_stg_q;
        dst_stg_d    = dst_stg_q;
        core_src_d   = core_src_q;
        start_pend_d = start_pend_q;
        auto_d       = auto_q;
        irq_en_d     = irq_en_q;
        ovf_d        = ovf_q;
        done_d       = done_q;
        bad_edge_d   = bad_edge_q;
        run_count_d  = run_count_q;
        readdata_d   = readdata_q;
        push         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty)            state_d = DRAIN;
                else if (start_pend_q) state_d = START;
            end
            // Leaves only once the FIFO is observed empty, one cycle after the last pop.
            DRAIN: begin
                if (empty) state_d = (start_pend_q || auto_q) ? START : IDLE;
            end
            START: begin
                state_d      = RUN;
                start_pend_d = 1'b0;
            end
            RUN: begin
                if (bus.core_done) begin
                    done_d      = 1'b1;
                    run_count_d = run_count_q + 32'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        core_start_d = (state_d == START);

        // Register writes come after the FSM so a start request and the
        // sticky clear override same-cycle FSM updates.
        if (wr_en) begin
            case (bus.address)
                3'd0: begin
                    src_stg_d = bus.writedata[2*PW-1:PW];
                    dst_stg_d = bus.writedata[PW-1:0];
                end
                3'd1: begin
                    if (src_stg_q == dst_stg_q) bad_edge_d = 1'b1;
                    else if (full && !pop)      ovf_d      = 1'b1;
                    else                        push       = 1'b1;
                end
                3'd2: begin
                    auto_d   = bus.writedata[1];
                    irq_en_d = bus.writedata[2];
                    if (bus.writedata[0]) start_pend_d = 1'b1;
                    if (bus.writedata[3]) begin
                        ovf_d      = 1'b0;
                        bad_edge_d = 1'b0;
                        done_d     = 1'b0;
                    end
                end
                3'd4: begin
                    if (state_q == IDLE) core_src_d = bus.writedata[PW-1:0];
                end
                default: ;
            endcase
        end

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (rd_en) begin
            case (bus.address)
                3'd3:    readdata_d = status;
                3'd4:    readdata_d = 32'(core_src_q);
                3'd5:    readdata_d = run_count_q;
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            src_stg_q    <= '0;
            dst_stg_q    <= '0;
            core_src_q   <= '0;
            start_pend_q <= 1'b0;
            auto_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            bad_edge_q   <= 1'b0;
            core_start_q <= 1'b0;
            run_count_q  <= '0;
            readdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            src_stg_q    <= src_stg_d;
            dst_stg_q    <= dst_stg_d;
            core_src_q   <= core_src_d;
            start_pend_q <= start_pend_d;
            auto_q       <= auto_d;
            irq_en_q     <= irq_en_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
            bad_edge_q   <= bad_edge_d;
            core_start_q <= core_start_d;
            run_count_q  <= run_count_d;
            readdata_q   <= readdata_d;
        end
    end

    // Queue storage needs no reset; the payload is masked while not valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign bus.upd_valid  = upd_valid;
    assign bus.upd_src    = upd_valid ? head[EW-1 -: PW] : '0;
    assign bus.upd_dst    = upd_valid ? head[WEIGHT_W +: PW] : '0;
    assign bus.upd_weight = upd_valid ? head[WEIGHT_W-1:0] : '0;
    assign bus.core_src   = core_src_q;
    assign bus.core_start = core_start_q;
    assign bus.irq        = irq_en_q && done_q;
    assign bus.readdata   = readdata_q;
endmodule

// File: doc/forex_update_ctrl.md
Name: forex_update_ctrl

Overview:
- Avalon-MM front-end for the arbitrage engine; next generation of the single-edge FOREX peripheral.
- Accepts edge-weight updates (src, dst, weight) from the HPS and queues them in a parametrised FIFO.
- Drains queued updates into the graph store, then launches one Bellman-Ford run on the container core, in manual or automatic mode.
- Reports status and run count over readdata; raises an interrupt when a run completes.

Parameters:
- NODES, 8, number of currencies; PW = $clog2(NODES), minimum 1.
- WEIGHT_W, 32, edge-weight width, two's complement.
- FIFO_DEPTH, 8, update queue depth; power of 2, at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- chipselect  in  1  Avalon select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  3  register index
- writedata  in  32  write data
- readdata  out  32  read data, registered
- upd_valid  out  1  update presented to graph store
- upd_ready  in  1  graph store accepts update
- upd_src  out  PW  edge source node
- upd_dst  out  PW  edge destination node
- upd_weight  out  WEIGHT_W  edge weight
- core_src  out  PW  Bellman-Ford source node
- core_start  out  1  one-cycle run pulse
- core_done  in  1  one-cycle run-complete pulse from core
- irq  out  1  level interrupt

Behaviour:
- Reset: all outputs 0, FIFO empty, all sticky bits 0, run_count 0, mode manual, FSM IDLE. A reset mid-run abandons the run; a core_done arriving after reset is ignored because the FSM is not in RUN.
- Register writes (chipselect && write):
  - addr0 STAGE: src_stg <= wd[2PW-1:PW]; dst_stg <= wd[PW-1:0].
  - addr1 WEIGHT: pushes {src_stg, dst_stg, wd[WEIGHT_W-1:0]}.
    - If src_stg == dst_stg: push dropped, bad_edge sticky set.
    - If FIFO full and no pop this cycle: push dropped, ovf sticky set.
    - If FIFO full and a pop occurs the same cycle: push accepted.
  - addr2 CTRL: wd[0]=1 sets start_pend; wd[1] auto mode; wd[2] irq_en; wd[3]=1 clears ovf, bad_edge and done. Clearing has priority over a same-cycle set.
  - addr4 SRC: core_src <= wd[PW-1:0]. Ignored while busy.
- Register reads (chipselect && read), readdata valid the next cycle; unmapped addresses return 0.
  - addr3 STATUS:
    - [0] busy (FSM != IDLE)
    - [1] full; [2] empty
    - [3] ovf; [4] done; [5] bad_edge
    - [6] start_pend; [7] auto
    - [15:8] FIFO count, zero-extended
  - addr5: run_count, 32-bit, wraps at 2^32.
  - addr4: core_src, zero-extended.
- FIFO: first-word fall-through; head drives upd_*; pop = upd_valid && upd_ready; count ranges 0..FIFO_DEPTH.
- FSM:
  - IDLE:
    - FIFO non-empty -> DRAIN.
    - Else if start_pend -> START.
  - DRAIN:
    - upd_valid = !empty.
    - Upd_* hold stable until accepted.
    - When FIFO becomes empty (after the last pop):
      - If start_pend or auto -> START.
      - Else -> IDLE.
  - START:
    - core_start = 1 for exactly one cycle.
    - Clears start_pend.
    - Next state -> RUN.
  - RUN:
    - upd_valid = 0; pushes continue to queue.
    - On core_done: done <= 1, run_count++, -> IDLE.
    - Start writes during RUN set start_pend; this yields one follow-on run.
- upd_valid is 0 outside DRAIN.
- Minimum latency: WEIGHT write at cycle t with upd_ready held 1:
  - upd_valid at t+2 (IDLE->DRAIN at t+1).
  - In auto mode, core_start at t+4.
- irq = irq_en && done.
- Weights pass through unmodified; no sign extension beyond WEIGHT_W.

Test Plan:
1. Reset, read addr3 -> 0x0000_0004 (empty only); addr5 -> 0.
2. Manual mode: STAGE src=2, dst=5; WEIGHT 0xFFFF_FF9C; ready=1 -> one beat upd_src=2, upd_dst=5, upd_weight=0xFFFF_FF9C; no core_start; FSM returns IDLE.
3. Auto mode: 3 updates, ready toggled 1/0 -> 3 beats in order, payload stable while ready=0; then one core_start pulse. Drive core_done -> done=1, run_count=1; irq=1 when irq_en=1.
4. Overflow: ready=0, FIFO_DEPTH+1 pushes -> count=8, full=1, ovf=1, last edge absent on drain; CTRL wd[3] clears ovf.
5. Self-loop: STAGE 3,3 then WEIGHT -> no push, bad_edge=1, count unchanged.
6. Start during RUN: pushes queue and upd_valid stays 0; core_done -> drain occurs, then a second core_start; reset asserted in RUN -> all outputs 0 next cycle, later core_done ignored, run_count=0.
